// File: rtl/seq_det_tdm_sched.sv
// +--------------------------------------------------------------------------+
// | seq_det_tdm_sched: round-robin TDM scheduler sharing one MSB-first Mealy |
// | pattern detector across NCH serial channels.       Revision: 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_det_tdm_sched #(
  parameter int              NCH     = 4,
  parameter int              CHW     = 2,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req_valid,
  input  logic [NCH-1:0]  req_bit,
  output logic [NCH-1:0]  req_ready,
  input  logic [NCH-1:0]  ch_clr,
  output logic            match_valid,
  output logic [CHW-1:0]  match_ch,
  input  logic [CHW-1:0]  cnt_sel,
  output logic [CNTW-1:0] cnt_out
);

  localparam int SW    = $clog2(PLEN);
  localparam int PAT_I = int'(PATTERN);

  // Longest prefix of PATTERN (shorter than PLEN) that ends the string formed
  // by the first s pattern bits followed by b.
  function automatic int calc_next(input int s, input int b);
    int seq_v;
    int lim;
    int best;
    seq_v = ((PAT_I >> (PLEN - s)) << 1) | b;
    lim   = (s + 1 < PLEN) ? s + 1 : PLEN - 1;
    best  = 0;
    for (int k = 1; k < PLEN; k++) begin
      if (k <= lim && (seq_v & ((1 << k) - 1)) == (PAT_I >> (PLEN - k))) begin
        best = k;
      end
    end
    return best;
  endfunction

  localparam logic [SW-1:0]   S_LAST        = SW'(PLEN - 1);
  localparam logic [SW-1:0]   S_BORDER      = SW'(calc_next(PLEN - 1, int'(PATTERN[0])));
  localparam logic [SW-1:0]   S_AFTER_MATCH = OVERLAP ? S_BORDER : '0;
  localparam logic [CNTW-1:0] CNT_MAX       = '1;

  logic [SW-1:0] nxt_tab [PLEN][2];

  generate
    for (genvar gs = 0; gs < PLEN; gs++) begin : g_tab_s
      for (genvar gb = 0; gb < 2; gb++) begin : g_tab_b
        assign nxt_tab[gs][gb] = SW'(calc_next(gs, gb));
      end
    end
  endgenerate

  logic [SW-1:0]   state_q [NCH];
  logic [SW-1:0]   state_d [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic            match_valid_q, match_valid_d;
  logic [CHW-1:0]  match_ch_q, match_ch_d;

  logic            grant_vld;
  logic [CHW-1:0]  grant_ch;
  logic [CHW-1:0]  arb_idx;
  logic            accept;
  logic            hit;
  logic [SW-1:0]   cur_s;
  logic            cur_b;

  // Scan from the farthest offset down so the nearest valid channel to ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    arb_idx   = '0;
    for (int off = NCH - 1; off >= 0; off--) begin
      arb_idx = CHW'((int'(ptr_q) + off) % NCH);
      if (req_valid[arb_idx]) begin
        grant_vld = 1'b1;
        grant_ch  = arb_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && grant_vld) begin
      req_ready[grant_ch] = 1'b1;
    end
  end

  // A clear on the granted channel still consumes the bit but suppresses the match.
  always_comb begin
    accept        = grant_vld & ~rst;
    cur_s         = state_q[grant_ch];
    cur_b         = req_bit[grant_ch];
    hit           = accept & ~ch_clr[grant_ch] & (cur_s == S_LAST) & (cur_b == PATTERN[0]);
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    match_valid_d = hit;
    match_ch_d    = hit ? grant_ch : match_ch_q;

    if (accept) begin
      state_d[grant_ch] = hit ? S_AFTER_MATCH : nxt_tab[cur_s][cur_b];
      ptr_d = (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        state_d[i] = '0;
      end
    end
    if (hit && cnt_q[grant_ch] != CNT_MAX) begin
      cnt_d[grant_ch] = cnt_q[grant_ch] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NCH) begin
      cnt_out = cnt_q[cnt_sel];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_det_tdm_sched.sv
// +--------------------------------------------------------------------------+
// | tb_seq_det_tdm_sched: directed bench for seq_det_tdm_sched, three        |
// | configurations sharing one stimulus.               Revision: 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_det_tdm_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_bit, ch_clr;
  logic [1:0] cnt_sel;

  logic [3:0]  rdy_a, rdy_b, rdy_c;
  logic        mv_a, mv_b, mv_c;
  logic [1:0]  mch_a, mch_b, mch_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_tdm_sched dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit), .req_ready(rdy_a),
    .ch_clr(ch_clr), .match_valid(mv_a), .match_ch(mch_a), .cnt_sel(cnt_sel), .cnt_out(cnt_a)
  );

  seq_det_tdm_sched #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit), .req_ready(rdy_b),
    .ch_clr(ch_clr), .match_valid(mv_b), .match_ch(mch_b), .cnt_sel(cnt_sel), .cnt_out(cnt_b)
  );

  seq_det_tdm_sched #(.CNTW(2)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit), .req_ready(rdy_c),
    .ch_clr(ch_clr), .match_valid(mv_c), .match_ch(mch_c), .cnt_sel(cnt_sel), .cnt_out(cnt_c)
  );

  task automatic apply(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr);
    @(negedge clk);
    req_valid = v;
    req_bit   = b;
    ch_clr    = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_bit = '0; ch_clr = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'hF; req_bit = 4'hF; ch_clr = '0; cnt_sel = 2'd0;
    #1;
    n_checks++;
    if (rdy_a !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", rdy_a); end
    tick();
    n_checks++;
    if (mv_a !== 1'b0) begin n_fail++; $display("FAIL reset_mv: got %b want 0", mv_a); end
    n_checks++;
    if (mch_a !== 2'd0) begin n_fail++; $display("FAIL reset_mch: got %0d want 0", mch_a); end
    n_checks++;
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_bit = '0;
  endtask

  task automatic test_overlap();
    logic bits  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_a [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_b [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(4'b0001, {3'b000, bits[i]}, 4'b0000);
      n_checks++;
      if (rdy_a !== 4'b0001) begin n_fail++; $display("FAIL t1_ready[%0d]: got %b want 0001", i, rdy_a); end
      tick();
      n_checks++;
      if (mv_a !== exp_a[i]) begin n_fail++; $display("FAIL t1_ovl_mv[%0d]: got %b want %b", i, mv_a, exp_a[i]); end
      n_checks++;
      if (mv_b !== exp_b[i]) begin n_fail++; $display("FAIL t1_noovl_mv[%0d]: got %b want %b", i, mv_b, exp_b[i]); end
      if (exp_a[i]) begin
        n_checks++;
        if (mch_a !== 2'd0) begin n_fail++; $display("FAIL t1_mch[%0d]: got %0d want 0", i, mch_a); end
      end
    end
    apply(4'b0000, 4'b0000, 4'b0000);
    cnt_sel = 2'd0;
    #1;
    n_checks++;
    if (rdy_a !== 4'b0000) begin n_fail++; $display("FAIL t1_idle_ready: got %b want 0000", rdy_a); end
    tick();
    n_checks++;
    if (mv_a !== 1'b0) begin n_fail++; $display("FAIL t1_idle_mv: got %b want 0", mv_a); end
    n_checks++;
    if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL t1_cnt_ovl: got %0d want 2", cnt_a); end
    n_checks++;
    if (cnt_b !== 16'd1) begin n_fail++; $display("FAIL t1_cnt_noovl: got %0d want 1", cnt_b); end
  endtask

  task automatic test_two_channels();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int n0 = 0;
    int n2 = 0;
    logic [3:0] b;
    logic [3:0] exp_rdy;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      b = 4'b0000;
      b[0] = pat[n0];
      b[2] = pat[n2];
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      apply(4'b0101, b, 4'b0000);
      n_checks++;
      if (rdy_a !== exp_rdy) begin n_fail++; $display("FAIL t3_ready[%0d]: got %b want %b", k, rdy_a, exp_rdy); end
      tick();
      n_checks++;
      if (mv_a !== (k >= 6)) begin n_fail++; $display("FAIL t3_mv[%0d]: got %b want %b", k, mv_a, (k >= 6)); end
      if (k >= 6) begin
        n_checks++;
        if (mch_a !== ((k == 6) ? 2'd0 : 2'd2)) begin
          n_fail++; $display("FAIL t3_mch[%0d]: got %0d want %0d", k, mch_a, (k == 6) ? 0 : 2);
        end
      end
      if (k % 2 == 0) n0++; else n2++;
    end
    apply(4'b0000, 4'b0000, 4'b0000);
    cnt_sel = 2'd0; #1;
    n_checks++;
    if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL t3_cnt0: got %0d want 1", cnt_a); end
    cnt_sel = 2'd2; #1;
    n_checks++;
    if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL t3_cnt2: got %0d want 1", cnt_a); end
    cnt_sel = 2'd1; #1;
    n_checks++;
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL t3_cnt1: got %0d want 0", cnt_a); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      apply(4'hF, 4'h0, 4'h0);
      n_checks++;
      if (rdy_a !== exp_rdy) begin n_fail++; $display("FAIL t4_ready[%0d]: got %b want %b", k, rdy_a, exp_rdy); end
      tick();
      n_checks++;
      if (mv_a !== 1'b0) begin n_fail++; $display("FAIL t4_mv[%0d]: got %b want 0", k, mv_a); end
    end
  endtask

  task automatic test_clear();
    logic pre  [3] = '{1'b1, 1'b0, 1'b1};
    logic post [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(4'b0010, {2'b00, pre[i], 1'b0}, 4'b0000);
      tick();
    end
    apply(4'b0010, 4'b0010, 4'b0010);
    n_checks++;
    if (rdy_a !== 4'b0010) begin n_fail++; $display("FAIL t5_clr_ready: got %b want 0010", rdy_a); end
    tick();
    n_checks++;
    if (mv_a !== 1'b0) begin n_fail++; $display("FAIL t5_clr_mv: got %b want 0", mv_a); end
    for (int i = 0; i < 4; i++) begin
      apply(4'b0010, {2'b00, post[i], 1'b0}, 4'b0000);
      tick();
      n_checks++;
      if (mv_a !== (i == 3)) begin n_fail++; $display("FAIL t5_mv[%0d]: got %b want %b", i, mv_a, (i == 3)); end
    end
    n_checks++;
    if (mch_a !== 2'd1) begin n_fail++; $display("FAIL t5_mch: got %0d want 1", mch_a); end
    apply(4'b0000, 4'b0000, 4'b0000);
    cnt_sel = 2'd1; #1;
    n_checks++;
    if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL t5_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_saturate_and_reset();
    logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(4'b1000, {pat[k % 4], 3'b000}, 4'b0000);
      tick();
      n_checks++;
      if (mv_c !== (k % 4 == 3)) begin n_fail++; $display("FAIL t6_mv[%0d]: got %b want %b", k, mv_c, (k % 4 == 3)); end
      if (k % 4 == 3) begin
        n_checks++;
        if (mch_c !== 2'd3) begin n_fail++; $display("FAIL t6_mch[%0d]: got %0d want 3", k, mch_c); end
      end
    end
    apply(4'b0000, 4'b0000, 4'b0000);
    cnt_sel = 2'd3; #1;
    n_checks++;
    if (cnt_c !== 2'd3) begin n_fail++; $display("FAIL t6_cnt_sat: got %0d want 3", cnt_c); end
    n_checks++;
    if (cnt_a !== 16'd5) begin n_fail++; $display("FAIL t6_cnt_wide: got %0d want 5", cnt_a); end
    for (int i = 0; i < 3; i++) begin
      apply(4'b1000, {pat[i], 3'b000}, 4'b0000);
      tick();
    end
    do_reset();
    #1;
    n_checks++;
    if (cnt_c !== 2'd0) begin n_fail++; $display("FAIL t6_cnt_after_rst: got %0d want 0", cnt_c); end
    n_checks++;
    if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL t6_cnt_wide_after_rst: got %0d want 0", cnt_a); end
    apply(4'b1000, 4'b1000, 4'b0000);
    n_checks++;
    if (rdy_c !== 4'b1000) begin n_fail++; $display("FAIL t6_ready: got %b want 1000", rdy_c); end
    tick();
    n_checks++;
    if (mv_c !== 1'b0) begin n_fail++; $display("FAIL t6_mv_after_rst: got %b want 0", mv_c); end
    n_checks++;
    if (mv_a !== 1'b0) begin n_fail++; $display("FAIL t6_mv_wide_after_rst: got %b want 0", mv_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_bit = '0; ch_clr = '0; cnt_sel = '0;
    test_reset();
    test_overlap();
    test_two_channels();
    test_round_robin();
    test_clear();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
